inv_mix_columns_serial: RTL and testbench



---
 rtl/inv_mix_columns_serial_pkg.sv | 50 +++++
 rtl/inv_mix_single_column.sv | 36 +++
 rtl/inv_mix_columns_serial.sv | 98 +++++++++
 tb/tb_inv_mix_columns_serial.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/inv_mix_columns_serial_pkg.sv
// Shared types and GF(2^8) helpers for the column-serial (Inv)MixColumns engine.
// Holds the state/column types, the FSM encoding, and constant multipliers
// over GF(2^8) with reduction polynomial 0x11B.
package inv_mix_columns_serial_pkg;

   // One column is four bytes; row r of a column is element [r].
   typedef logic [3:0][7:0] column_t;

   // Sixteen bytes arranged as four columns: st[c][r] is byte 4c+r.
   typedef column_t [3:0] state_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mixcol_fsm_t;

   function automatic logic [7:0] gf_mult_by2(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mult_by3(input logic [7:0] a);
      return gf_mult_by2(a) ^ a;
   endfunction

   function automatic logic [7:0] gf_mult_by9(input logic [7:0] a);
      return gf_mult_by2(gf_mult_by2(gf_mult_by2(a))) ^ a;
   endfunction

   function automatic logic [7:0] gf_mult_by11(input logic [7:0] a);
      logic [7:0] x2;
      x2 = gf_mult_by2(a);
      return gf_mult_by2(gf_mult_by2(x2)) ^ x2 ^ a;
   endfunction

   function automatic logic [7:0] gf_mult_by13(input logic [7:0] a);
      logic [7:0] x4;
      x4 = gf_mult_by2(gf_mult_by2(a));
      return gf_mult_by2(x4) ^ x4 ^ a;
   endfunction

   function automatic logic [7:0] gf_mult_by14(input logic [7:0] a);
      logic [7:0] x2;
      logic [7:0] x4;
      x2 = gf_mult_by2(a);
      x4 = gf_mult_by2(x2);
      return gf_mult_by2(x4) ^ x4 ^ x2;
   endfunction

endpackage

// File: rtl/inv_mix_single_column.sv
// Combinational single-column (Inv)MixColumns unit.
// Inverse matrix by default; the forward matrix and the fwd select input are
// compiled in only when AES_MIXCOL_FWD_EN is defined.
module inv_mix_single_column
   import inv_mix_columns_serial_pkg::*;
(
`ifdef AES_MIXCOL_FWD_EN
   input  logic    fwd,
`endif
   input  column_t column,
   output column_t result
);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_row
         // Each output row uses the first matrix row rotated right by the row index.
         logic [7:0] inv_byte;
         assign inv_byte = gf_mult_by14(column[gi])
                         ^ gf_mult_by11(column[(gi + 1) % 4])
                         ^ gf_mult_by13(column[(gi + 2) % 4])
                         ^ gf_mult_by9 (column[(gi + 3) % 4]);
`ifdef AES_MIXCOL_FWD_EN
         logic [7:0] fwd_byte;
         assign fwd_byte = gf_mult_by2(column[gi])
                         ^ gf_mult_by3(column[(gi + 1) % 4])
                         ^ column[(gi + 2) % 4]
                         ^ column[(gi + 3) % 4];
         assign result[gi] = fwd ? fwd_byte : inv_byte;
`else
         assign result[gi] = inv_byte;
`endif
      end
   endgenerate

endmodule

// File: rtl/inv_mix_columns_serial.sv
// Column-serial InvMixColumns engine: accepts a 128-bit state on a valid/ready
// handshake, transforms one column per clock over four cycles, then holds the
// result on an output valid/ready handshake.
// Optional macro AES_MIXCOL_FWD_EN adds a per-transaction mode input that
// selects forward MixColumns (mode=1) instead of the inverse.
module inv_mix_columns_serial
   import inv_mix_columns_serial_pkg::*;
(
   input  logic   clock,
   input  logic   reset,
   input  logic   in_valid,
   output logic   in_ready,
   input  state_t in_state,
`ifdef AES_MIXCOL_FWD_EN
   input  logic   mode,
`endif
   output logic   out_valid,
   input  logic   out_ready,
   output state_t out_state
);

   mixcol_fsm_t fsm;
   logic [1:0]  col;
   state_t      st;
   column_t     cur_column;
   column_t     new_column;

   // Only the column addressed by the counter feeds the single multiplier unit.
   assign cur_column = st[col];

`ifdef AES_MIXCOL_FWD_EN
   logic fwd_sel;

   inv_mix_single_column u_column (
      .fwd    (fwd_sel),
      .column (cur_column),
      .result (new_column)
   );
`else
   inv_mix_single_column u_column (
      .column (cur_column),
      .result (new_column)
   );
`endif

   // Output comes straight from the state register, so no input reaches it combinationally.
   assign out_state = st;

   // Handshake FSM with registered ready/valid, column counter and state register.
   always_ff @(posedge clock) begin
      if (reset) begin
         fsm       <= IDLE;
         col       <= 2'd0;
         st        <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
`ifdef AES_MIXCOL_FWD_EN
         fwd_sel   <= 1'b0;
`endif
      end else begin
         case (fsm)
            IDLE: begin
               if (in_valid) begin
                  st       <= in_state;
                  col      <= 2'd0;
                  in_ready <= 1'b0;
                  fsm      <= BUSY;
`ifdef AES_MIXCOL_FWD_EN
                  fwd_sel  <= mode;
`endif
               end
            end
            BUSY: begin
               st[col] <= new_column;
               col     <= col + 2'd1;
               if (col == 2'd3) begin
                  out_valid <= 1'b1;
                  fsm       <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  fsm       <= IDLE;
               end
            end
            default: begin
               fsm       <= IDLE;
               col       <= 2'd0;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inv_mix_columns_serial.sv
// Self-checking bench for inv_mix_columns_serial: table vectors, random states
// against a generic GF(2^8) matrix model, back-pressure and mid-BUSY reset.
// Forward-mode sequence compiled only when AES_MIXCOL_FWD_EN is defined.
module tb_inv_mix_columns_serial;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [127:0] in_state = '0;
   logic         mode = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [127:0] out_state;

   int checks = 0;
   int errors = 0;

   inv_mix_columns_serial dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_state  (in_state),
`ifdef AES_MIXCOL_FWD_EN
      .mode      (mode),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_state (out_state)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [127:0] stim;
      logic [127:0] expect_state;
   } vec_t;

   // Generic shift-and-add multiply in GF(2^8), polynomial 0x11B.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      logic [7:0] y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
         y = y >> 1;
      end
      return p;
   endfunction

   // Full-state matrix product; row r of the matrix is row 0 rotated right by r.
   function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic fwd);
      logic [7:0] row0 [4];
      logic [127:0] r = '0;
      logic [7:0] acc;
      if (fwd) row0 = '{8'd2, 8'd3, 8'd1, 8'd1};
      else     row0 = '{8'd14, 8'd11, 8'd13, 8'd9};
      for (int c = 0; c < 4; c++) begin
         for (int rw = 0; rw < 4; rw++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++)
               acc = acc ^ gf_mul(row0[(k - rw + 4) % 4], s[32*c + 8*k +: 8]);
            r[32*c + 8*rw +: 8] = acc;
         end
      end
      return r;
   endfunction

   // Builds a state from four columns written top-to-bottom (row 0 in the high byte).
   function automatic logic [127:0] mk_state(input logic [31:0] c0, input logic [31:0] c1,
                                             input logic [31:0] c2, input logic [31:0] c3);
      logic [31:0] cw [4];
      logic [127:0] s = '0;
      cw = '{c0, c1, c2, c3};
      for (int c = 0; c < 4; c++)
         for (int rw = 0; rw < 4; rw++)
            s[32*c + 8*rw +: 8] = cw[c][31 - 8*rw -: 8];
      return s;
   endfunction

   task automatic check(input string name, input logic [127:0] actual, input logic [127:0] required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, actual, required);
      end
   endtask

   // Full transaction with out_ready high: checks acceptance, latency, result and release.
   task automatic run_txn(input string name, input logic [127:0] stim, input logic fwd,
                          input logic [127:0] required, output logic [127:0] result);
      int lat;
      in_state = stim;
      mode     = fwd;
      in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      check({name, " accepted"}, {127'd0, in_ready}, 128'd0);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clock); #1;
         lat++;
      end
      check({name, " latency"}, 128'(lat), 128'd4);
      check({name, " result"}, out_state, required);
      result = out_state;
      $display("txn %s: in=%h out=%h latency=%0d", name, stim, out_state, lat);
      @(posedge clock); #1;
      check({name, " released"}, {126'd0, in_ready, out_valid}, 128'd2);
   endtask

   initial begin
      vec_t tbl [2];
      logic [127:0] res;
      logic [127:0] held;
      logic [127:0] s;
      logic seen;

      tbl[0].stim         = mk_state(32'h8e4da1bc, 32'h8e4da1bc, 32'h8e4da1bc, 32'h8e4da1bc);
      tbl[0].expect_state = mk_state(32'hdb135345, 32'hdb135345, 32'hdb135345, 32'hdb135345);
      tbl[1].stim         = mk_state(32'h9fdc589d, 32'h4d7ebdf8, 32'h01010101, 32'hc6c6c6c6);
      tbl[1].expect_state = mk_state(32'hf20a225c, 32'h2d26314c, 32'h01010101, 32'hc6c6c6c6);

      // Reset and idle values
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(posedge clock); #1;
      check("reset in_ready", {127'd0, in_ready}, 128'd1);
      check("reset out_valid", {127'd0, out_valid}, 128'd0);
      check("reset out_state", out_state, 128'd0);

      // Table vectors, also cross-checked against the model
      for (int i = 0; i < 2; i++) begin
         run_txn($sformatf("table%0d", i), tbl[i].stim, 1'b0, tbl[i].expect_state, res);
         check($sformatf("table%0d model", i), res, ref_mix(tbl[i].stim, 1'b0));
      end

      // Random states against the model
      for (int i = 0; i < 20; i++) begin
         s = {$urandom, $urandom, $urandom, $urandom};
         run_txn($sformatf("rand%0d", i), s, 1'b0, ref_mix(s, 1'b0), res);
      end

      // Back-pressure: result held, in_valid pulses ignored
      out_ready = 1'b0;
      in_state  = tbl[1].stim;
      in_valid  = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      check("bp valid", {127'd0, out_valid}, 128'd1);
      held = out_state;
      check("bp first result", held, tbl[1].expect_state);
      for (int i = 0; i < 10; i++) begin
         in_state = tbl[0].stim;
         in_valid = i[0];
         @(posedge clock); #1;
         check($sformatf("bp hold %0d", i), {out_state, out_valid, in_ready},
               {tbl[1].expect_state, 1'b1, 1'b0});
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clock); #1;
      check("bp handshake", {126'd0, in_ready, out_valid}, 128'd2);
      $display("txn backpressure: held=%h", held);
      run_txn("after bp", tbl[0].stim, 1'b0, tbl[0].expect_state, res);

      // Reset while BUSY at col=2
      s = {$urandom, $urandom, $urandom, $urandom};
      in_state = s;
      in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      check("midreset in_ready", {127'd0, in_ready}, 128'd1);
      check("midreset out_valid", {127'd0, out_valid}, 128'd0);
      check("midreset st", out_state, 128'd0);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clock); #1;
         if (out_valid) seen = 1'b1;
      end
      check("midreset no output", {127'd0, seen}, 128'd0);
      $display("txn midreset: in=%h discarded", s);
      run_txn("post reset", tbl[1].stim, 1'b0, tbl[1].expect_state, res);

`ifdef AES_MIXCOL_FWD_EN
      // Forward then inverse round trip, back to back
      run_txn("fwd", tbl[0].expect_state, 1'b1, tbl[0].stim, res);
      run_txn("inv back", res, 1'b0, tbl[0].expect_state, res);
      for (int i = 0; i < 4; i++) begin
         s = {$urandom, $urandom, $urandom, $urandom};
         run_txn($sformatf("fwd rand%0d", i), s, 1'b1, ref_mix(s, 1'b1), res);
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
